// File: rtl/fetch_pkg.sv
// fetch_pkg: shared types and constants for the instruction-fetch stage.
//   XLEN          - architectural word width carried in queue entries
//   NOP_INSTR     - canonical RISC-V nop (addi x0, x0, 0)
//   INSTR_BYTES   - fetch stride in bytes
//   fetch_entry_t - queued {pc, instr} pair
//   fetch_state_e - status FSM: RUN (no stale responses) / DRAIN (discarding)
//   word_align    - clears the byte-offset bits of an address
package fetch_pkg;

  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;
  localparam int INSTR_BYTES = 4;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
  } fetch_entry_t;

  typedef enum logic {
    RUN   = 1'b0,
    DRAIN = 1'b1
  } fetch_state_e;

  function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] addr);
    return addr & ~XLEN'(3);
  endfunction

endpackage

// File: rtl/fetch_queue.sv
// fetch_queue: synchronous FIFO of fetch_entry_t between memory responses and decode.
//   clk_in, rst_in - clock, asynchronous active-low reset (pointers only)
//   flush          - empties the queue; overrides push and pop in the same cycle
//   push, push_entry - write one entry at the tail
//   pop            - remove the head (caller only pops when count != 0)
//   count          - number of valid entries, 0..DEPTH
//   head           - entry at the head (meaningless when count == 0)
module fetch_queue
  import fetch_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  logic         clk_in,
  input  logic         rst_in,
  input  logic         flush,
  input  logic         push,
  input  fetch_entry_t push_entry,
  input  logic         pop,
  output logic [PTR_W:0] count,
  output fetch_entry_t head
);

  localparam logic [PTR_W:0] PTR_ONE = {{PTR_W{1'b0}}, 1'b1};

  fetch_entry_t   mem [DEPTH];
  logic [PTR_W:0] wr_ptr;
  logic [PTR_W:0] rd_ptr;

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
    end
  end

  always_ff @(posedge clk_in) begin
    if (push && !flush) mem[wr_ptr[PTR_W-1:0]] <= push_entry;
  end

  assign count = wr_ptr - rd_ptr;
  assign head  = mem[rd_ptr[PTR_W-1:0]];

endmodule

// File: rtl/instr_fetch.sv
// instr_fetch: decoupled instruction-fetch stage feeding decode.
//   clk_in, rst_in            - clock, asynchronous active-low reset
//   imem_req_valid_out/ready_in, imem_addr_out - word request channel to imem
//   imem_resp_valid_in, imem_resp_data_in      - in-order responses
//   redirect_in, redirect_pc_in               - flush and refetch from a new PC
//   Instr_valid_out/ready_in, Instr_out, PC_out - queue head towards decode
// Requests are credit-limited (outstanding + queued < DEPTH) so every response
// always has a queue slot. Responses still in flight at a redirect are counted
// in discard_cnt and dropped on arrival.
module instr_fetch
  import fetch_pkg::*;
#(
  parameter int               WIDTH    = 32,
  parameter int               DEPTH    = 4,
  parameter logic [WIDTH-1:0] RESET_PC = '0
) (
  input  logic             clk_in,
  input  logic             rst_in,
  output logic             imem_req_valid_out,
  input  logic             imem_req_ready_in,
  output logic [WIDTH-1:0] imem_addr_out,
  input  logic             imem_resp_valid_in,
  input  logic [WIDTH-1:0] imem_resp_data_in,
  input  logic             redirect_in,
  input  logic [WIDTH-1:0] redirect_pc_in,
  output logic             Instr_valid_out,
  input  logic             Instr_ready_in,
  output logic [WIDTH-1:0] Instr_out,
  output logic [WIDTH-1:0] PC_out
);

  localparam int CNT_W = $clog2(DEPTH) + 1;
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W:0]   CREDITS = (CNT_W+1)'(DEPTH);
  localparam logic [WIDTH-1:0] PC_STEP = WIDTH'(INSTR_BYTES);

  logic [WIDTH-1:0] fetch_pc;
  logic [WIDTH-1:0] resp_pc;
  logic [CNT_W-1:0] outstanding;
  logic [CNT_W-1:0] discard_cnt;
  logic [CNT_W-1:0] discard_nxt;
  logic [CNT_W-1:0] q_count;
  fetch_state_e     state;
  logic [WIDTH-1:0] target_pc;
  logic             req_fire;
  logic             resp_ok;
  logic             resp_drop;
  logic             q_valid;
  logic             q_push;
  logic             q_pop;
  fetch_entry_t     push_entry;
  fetch_entry_t     q_head;

  assign target_pc = word_align(redirect_pc_in);

  // Request path depends only on counters, reset and redirect, never on ready.
  assign imem_req_valid_out = rst_in && !redirect_in &&
                              (({1'b0, outstanding} + {1'b0, q_count}) < CREDITS);
  assign imem_addr_out = fetch_pc;
  assign req_fire      = imem_req_valid_out && imem_req_ready_in;

  // A response with nothing outstanding is a protocol error and is ignored.
  assign resp_ok   = imem_resp_valid_in && (outstanding != '0);
  assign resp_drop = resp_ok && (state == DRAIN);

  assign q_valid = (q_count != '0);
  assign q_push  = resp_ok && !resp_drop && !redirect_in;
  assign q_pop   = q_valid && Instr_ready_in && !redirect_in;

  assign push_entry = '{pc: resp_pc, instr: imem_resp_data_in};

  // Stale responses from an earlier redirect are already part of outstanding,
  // so after a redirect everything still in flight is to be discarded.
  always_comb begin
    discard_nxt = discard_cnt;
    if (redirect_in)
      discard_nxt = outstanding - (resp_ok ? CNT_ONE : '0);
    else if (resp_drop)
      discard_nxt = discard_cnt - CNT_ONE;
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      fetch_pc    <= RESET_PC;
      resp_pc     <= RESET_PC;
      outstanding <= '0;
      discard_cnt <= '0;
      state       <= RUN;
    end else begin
      case ({req_fire, resp_ok})
        2'b10:   outstanding <= outstanding + CNT_ONE;
        2'b01:   outstanding <= outstanding - CNT_ONE;
        default: outstanding <= outstanding;
      endcase
      discard_cnt <= discard_nxt;
      state       <= (discard_nxt != '0) ? DRAIN : RUN;
      if (redirect_in) begin
        fetch_pc <= target_pc;
        resp_pc  <= target_pc;
      end else begin
        if (req_fire) fetch_pc <= fetch_pc + PC_STEP;
        if (q_push)   resp_pc  <= resp_pc + PC_STEP;
      end
    end
  end

  fetch_queue #(.DEPTH(DEPTH)) u_queue (
    .clk_in     (clk_in),
    .rst_in     (rst_in),
    .flush      (redirect_in),
    .push       (q_push),
    .push_entry (push_entry),
    .pop        (q_pop),
    .count      (q_count),
    .head       (q_head)
  );

  assign Instr_valid_out = q_valid;
  assign Instr_out       = q_valid ? q_head.instr : '0;
  assign PC_out          = q_valid ? q_head.pc    : '0;

endmodule

// File: tb/tb_instr_fetch.sv
module tb_instr_fetch;

  logic        clk_in = 1'b0;
  logic        rst_in;
  logic        imem_req_valid_out;
  logic        imem_req_ready_in;
  logic [31:0] imem_addr_out;
  logic        imem_resp_valid_in;
  logic [31:0] imem_resp_data_in;
  logic        redirect_in;
  logic [31:0] redirect_pc_in;
  logic        Instr_valid_out;
  logic        Instr_ready_in;
  logic [31:0] Instr_out;
  logic [31:0] PC_out;

  instr_fetch #(.WIDTH(32), .DEPTH(4), .RESET_PC(32'h0)) dut (
    .clk_in             (clk_in),
    .rst_in             (rst_in),
    .imem_req_valid_out (imem_req_valid_out),
    .imem_req_ready_in  (imem_req_ready_in),
    .imem_addr_out      (imem_addr_out),
    .imem_resp_valid_in (imem_resp_valid_in),
    .imem_resp_data_in  (imem_resp_data_in),
    .redirect_in        (redirect_in),
    .redirect_pc_in     (redirect_pc_in),
    .Instr_valid_out    (Instr_valid_out),
    .Instr_ready_in     (Instr_ready_in),
    .Instr_out          (Instr_out),
    .PC_out             (PC_out)
  );

  always #5 clk_in = ~clk_in;

  int total = 0;
  int bad   = 0;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } exp_t;

  typedef struct {
    logic [31:0] addr;
    int          due;
  } mreq_t;

  exp_t        exp_q[$];
  mreq_t       mem_q[$];
  logic [31:0] issued[$];
  int          cyc = 0;
  int          lat = 1;
  exp_t        mon_e;

  function automatic logic [31:0] instr_of(input logic [31:0] a);
    return {a[15:0], 16'h0013} ^ 32'h5A00_0000;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %h, expected %h", name, act, req);
    end
  endtask

  task automatic expect_pc(input logic [31:0] pc);
    exp_q.push_back('{pc: pc, instr: instr_of(pc)});
  endtask

  task automatic step();
    @(posedge clk_in);
    #1;
  endtask

  // Memory model: in-order responses after 'lat' cycles, one per cycle.
  always begin
    @(posedge clk_in);
    if (!rst_in) begin
      mem_q.delete();
    end else begin
      if (imem_resp_valid_in && mem_q.size() > 0) void'(mem_q.pop_front());
      if (imem_req_valid_out && imem_req_ready_in) begin
        mem_q.push_back('{addr: imem_addr_out, due: cyc + lat});
        issued.push_back(imem_addr_out);
      end
    end
    cyc++;
    #1;
    if (rst_in && mem_q.size() > 0 && mem_q[0].due <= cyc) begin
      imem_resp_valid_in = 1'b1;
      imem_resp_data_in  = instr_of(mem_q[0].addr);
    end else begin
      imem_resp_valid_in = 1'b0;
      imem_resp_data_in  = '0;
    end
  end

  // Scoreboard monitor: every consumed head must match the next expected entry.
  always @(negedge clk_in) begin
    if (rst_in && !redirect_in) begin
      if (Instr_valid_out) begin
        if (Instr_ready_in) begin
          if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_pop: got pc %h instr %h, expected none", PC_out, Instr_out);
          end else begin
            mon_e = exp_q.pop_front();
            check("pop_pc", PC_out, mon_e.pc);
            check("pop_instr", Instr_out, mon_e.instr);
          end
        end
      end else begin
        check("idle_instr", Instr_out, 32'h0);
        check("idle_pc", PC_out, 32'h0);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1);
  end

  initial begin
    int base;
    rst_in             = 1'b0;
    imem_req_ready_in  = 1'b0;
    imem_resp_valid_in = 1'b0;
    imem_resp_data_in  = '0;
    redirect_in        = 1'b0;
    redirect_pc_in     = '0;
    Instr_ready_in     = 1'b0;

    // Reset state
    repeat (3) step();
    @(negedge clk_in);
    check("rst_req_valid", 32'(imem_req_valid_out), 32'h0);
    check("rst_instr_valid", 32'(Instr_valid_out), 32'h0);
    check("rst_instr", Instr_out, 32'h0);
    check("rst_pc", PC_out, 32'h0);

    // Streaming, latency 1, decode always ready
    step();
    rst_in = 1'b1;
    imem_req_ready_in = 1'b1;
    Instr_ready_in = 1'b1;
    lat = 1;
    for (int i = 0; i < 6; i++) expect_pc(32'(i * 4));
    for (int k = 0; k < 6; k++) begin
      if (k > 0) step();
      @(negedge clk_in);
      check("stream_req_valid", 32'(imem_req_valid_out), 32'h1);
      check("stream_addr", imem_addr_out, 32'(k * 4));
      if (k < 2) check("stream_early_valid", 32'(Instr_valid_out), 32'h0);
      else       check("stream_valid", 32'(Instr_valid_out), 32'h1);
    end
    step();
    imem_req_ready_in = 1'b0;
    @(negedge clk_in);
    check("hold_valid", 32'(imem_req_valid_out), 32'h1);
    check("hold_addr", imem_addr_out, 32'h18);
    step();
    @(negedge clk_in);
    check("hold_addr2", imem_addr_out, 32'h18);
    repeat (5) step();
    check("stream_drained", 32'(exp_q.size()), 32'h0);
    check("stream_issued", 32'(issued.size()), 32'd6);

    // Decode stall: credit limit of DEPTH requests
    base = issued.size();
    imem_req_ready_in = 1'b1;
    Instr_ready_in = 1'b0;
    for (int i = 0; i < 4; i++) expect_pc(32'h18 + 32'(i * 4));
    repeat (7) step();
    @(negedge clk_in);
    check("stall_issued", 32'(issued.size() - base), 32'd4);
    check("stall_req_valid", 32'(imem_req_valid_out), 32'h0);
    check("stall_head_valid", 32'(Instr_valid_out), 32'h1);
    check("stall_head_pc", PC_out, 32'h18);
    check("stall_head_instr", Instr_out, instr_of(32'h18));
    step();
    Instr_ready_in = 1'b1;
    imem_req_ready_in = 1'b0;
    @(negedge clk_in);
    check("stall_full_valid", 32'(imem_req_valid_out), 32'h0);
    step();
    @(negedge clk_in);
    check("resume_valid", 32'(imem_req_valid_out), 32'h1);
    check("resume_addr", imem_addr_out, 32'h28);
    repeat (5) step();
    check("stall_drained", 32'(exp_q.size()), 32'h0);
    check("stall_issued_final", 32'(issued.size() - base), 32'd4);

    // Redirect with two responses in flight at latency 3
    base = issued.size();
    lat = 3;
    imem_req_ready_in = 1'b1;
    step();
    step();
    redirect_in = 1'b1;
    redirect_pc_in = 32'h0000_0103;
    expect_pc(32'h100);
    @(negedge clk_in);
    check("redir_req_valid", 32'(imem_req_valid_out), 32'h0);
    step();
    redirect_in = 1'b0;
    @(negedge clk_in);
    check("redir_new_valid", 32'(imem_req_valid_out), 32'h1);
    check("redir_new_addr", imem_addr_out, 32'h100);
    step();
    imem_req_ready_in = 1'b0;
    step();
    step();
    @(negedge clk_in);
    check("redir_not_yet", 32'(Instr_valid_out), 32'h0);
    step();
    @(negedge clk_in);
    check("redir_first_valid", 32'(Instr_valid_out), 32'h1);
    check("redir_first_pc", PC_out, 32'h100);
    repeat (3) step();
    check("redir_drained", 32'(exp_q.size()), 32'h0);
    check("redir_issued", 32'(issued.size() - base), 32'd3);

    // Redirect coinciding with a response and a pop (latency 2)
    lat = 2;
    imem_req_ready_in = 1'b1;
    step();
    step();
    step();
    redirect_in = 1'b1;
    redirect_pc_in = 32'h0000_0200;
    expect_pc(32'h200);
    @(negedge clk_in);
    check("coinc_head_valid", 32'(Instr_valid_out), 32'h1);
    check("coinc_head_pc", PC_out, 32'h104);
    check("coinc_req_valid", 32'(imem_req_valid_out), 32'h0);
    step();
    redirect_in = 1'b0;
    @(negedge clk_in);
    check("coinc_flushed", 32'(Instr_valid_out), 32'h0);
    check("coinc_new_addr", imem_addr_out, 32'h200);
    check("coinc_new_valid", 32'(imem_req_valid_out), 32'h1);
    step();
    imem_req_ready_in = 1'b0;
    @(negedge clk_in);
    check("coinc_drop_a", 32'(Instr_valid_out), 32'h0);
    step();
    @(negedge clk_in);
    check("coinc_drop_b", 32'(Instr_valid_out), 32'h0);
    step();
    @(negedge clk_in);
    check("coinc_first_pc", PC_out, 32'h200);
    repeat (3) step();
    check("coinc_drained", 32'(exp_q.size()), 32'h0);

    // Redirect to the top word: address wraps to zero
    step();
    lat = 1;
    redirect_in = 1'b1;
    redirect_pc_in = 32'hFFFF_FFFC;
    expect_pc(32'hFFFF_FFFC);
    expect_pc(32'h0);
    @(negedge clk_in);
    check("wrap_redir_valid", 32'(imem_req_valid_out), 32'h0);
    step();
    redirect_in = 1'b0;
    imem_req_ready_in = 1'b1;
    @(negedge clk_in);
    check("wrap_addr_top", imem_addr_out, 32'hFFFF_FFFC);
    step();
    @(negedge clk_in);
    check("wrap_addr_zero", imem_addr_out, 32'h0);
    step();
    imem_req_ready_in = 1'b0;
    repeat (4) step();
    check("wrap_drained", 32'(exp_q.size()), 32'h0);

    // Asynchronous reset with three entries queued
    Instr_ready_in = 1'b0;
    imem_req_ready_in = 1'b1;
    step();
    step();
    step();
    imem_req_ready_in = 1'b0;
    step();
    @(negedge clk_in);
    check("pre_rst_valid", 32'(Instr_valid_out), 32'h1);
    check("pre_rst_pc", PC_out, 32'h4);
    #2;
    rst_in = 1'b0;
    #1;
    check("async_instr_valid", 32'(Instr_valid_out), 32'h0);
    check("async_instr", Instr_out, 32'h0);
    check("async_pc", PC_out, 32'h0);
    check("async_req_valid", 32'(imem_req_valid_out), 32'h0);
    step();
    step();
    rst_in = 1'b1;
    imem_req_ready_in = 1'b1;
    Instr_ready_in = 1'b1;
    expect_pc(32'h0);
    expect_pc(32'h4);
    @(negedge clk_in);
    check("restart_valid", 32'(imem_req_valid_out), 32'h1);
    check("restart_addr", imem_addr_out, 32'h0);
    step();
    @(negedge clk_in);
    check("restart_addr2", imem_addr_out, 32'h4);
    step();
    imem_req_ready_in = 1'b0;
    repeat (5) step();
    check("restart_drained", 32'(exp_q.size()), 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
